// File: rtl/qsv_ctrl_pkg.sv
// Shared definitions for the microcoded sequencer: control-word field layout,
// sequencer states, and a packed view of the word as the datapath sees it.
package qsv_ctrl_pkg;

  localparam int SAMPLE_SIZE = 4;
  localparam int CTRL_WIDTH  = 13;
  localparam int DEPTH       = 16;
  localparam int ADDR_BIT    = 4;

  localparam int LD_LSB         = 0;
  localparam int LD_W           = SAMPLE_SIZE;
  localparam int SEL_REG0_LSB   = 4;
  localparam int SEL_REG0_W     = 1;
  localparam int SEL_REG1_LSB   = 5;
  localparam int SEL_REG1_W     = 2;
  localparam int SEL_REG2_LSB   = 7;
  localparam int SEL_REG2_W     = 2;
  localparam int SEL_REG3_LSB   = 9;
  localparam int SEL_REG3_W     = 2;
  localparam int SEL_ALU0_2_LSB = 11;
  localparam int SEL_ALU1_1_LSB = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Field order is MSB first so the packed struct overlays the raw word.
  typedef struct packed {
    logic                   sel_alu1_1;
    logic                   sel_alu0_2;
    logic [SEL_REG3_W-1:0]  sel_reg3;
    logic [SEL_REG2_W-1:0]  sel_reg2;
    logic [SEL_REG1_W-1:0]  sel_reg1;
    logic [SEL_REG0_W-1:0]  sel_reg0;
    logic [LD_W-1:0]        ld;
  } ctrl_word_t;

endpackage

// File: rtl/qsv_prog_table.sv
// Program store: register file of control words, one write port,
// asynchronous read, cleared by reset.
module qsv_prog_table
  import qsv_ctrl_pkg::*;
#(
  parameter int ctrl_width = CTRL_WIDTH,
  parameter int depth      = DEPTH,
  parameter int addr_bit   = ADDR_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [addr_bit-1:0]   waddr,
  input  logic [ctrl_width-1:0] wdata,
  input  logic [addr_bit-1:0]   raddr,
  output logic [ctrl_width-1:0] rdata
);

  logic [ctrl_width-1:0] mem_q [depth];
  logic [ctrl_width-1:0] mem_d [depth];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/qsv_microseq.sv
// Microcoded control unit: replays table words 0..len-1 onto the datapath
// select/load lines, with stall, abort and config-write guarding.
module qsv_microseq
  import qsv_ctrl_pkg::*;
#(
  parameter int sample_size = SAMPLE_SIZE,
  parameter int ctrl_width  = CTRL_WIDTH,
  parameter int depth       = DEPTH,
  parameter int addr_bit    = ADDR_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [addr_bit-1:0]   cfg_addr,
  input  logic [ctrl_width-1:0] cfg_data,
  input  logic [addr_bit:0]     prog_len,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  abort,
  output logic [ctrl_width-1:0] ctrl_word,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  cfg_err,
  output logic [addr_bit-1:0]   pc
);

  localparam logic [ctrl_width-1:0] LD_MASK =
    {{(ctrl_width-sample_size){1'b0}}, {sample_size{1'b1}}};
  localparam logic [addr_bit:0] DEPTH_LEN = (addr_bit+1)'(depth);

  state_e                state_q, state_d;
  logic [addr_bit-1:0]   pc_q, pc_d;
  logic [addr_bit:0]     len_q, len_d;
  logic                  aborted_q, aborted_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  cfg_ok;
  logic [addr_bit:0]     len_sat;
  logic [ctrl_width-1:0] rd_word;

  assign cfg_ok  = cfg_we && (state_q == ST_IDLE);
  assign len_sat = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;

  qsv_prog_table #(
    .ctrl_width (ctrl_width),
    .depth      (depth),
    .addr_bit   (addr_bit)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_ok),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (pc_q),
    .rdata (rd_word)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    aborted_d = 1'b0;
    cfg_err_d = cfg_we && (state_q != ST_IDLE);
    ctrl_word = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len_sat;
          pc_d    = '0;
          state_d = (len_sat == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        // Abort outranks hold and completion; the word is blanked in that same cycle.
        if (abort) begin
          aborted_d = 1'b1;
          pc_d      = '0;
          state_d   = ST_IDLE;
        end else if (hold) begin
          ctrl_word = rd_word & ~LD_MASK;
        end else begin
          ctrl_word = rd_word;
          if ({1'b0, pc_q} == len_q - 1'b1) begin
            pc_d    = '0;
            state_d = ST_DONE;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        pc_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        pc_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pc      = pc_q;
  assign aborted = aborted_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_qsv_microseq.sv
// Directed bench for qsv_microseq: expected per-cycle outputs are queued as
// stimulus is applied and popped against the DUT each cycle.
module tb_qsv_microseq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [12:0] cfg_data;
  logic [4:0]  prog_len;
  logic        start, hold, abort;
  logic [12:0] ctrl_word;
  logic        busy, done, aborted, cfg_err;
  logic [3:0]  pc;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [12:0] cw;
    logic        busy;
    logic        done;
    logic        abt;
    logic        err;
    logic [3:0]  pc;
  } exp_t;

  exp_t        sb[$];
  logic [12:0] prog [5];

  qsv_microseq dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .prog_len  (prog_len),
    .start     (start),
    .hold      (hold),
    .abort     (abort),
    .ctrl_word (ctrl_word),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .cfg_err   (cfg_err),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [12:0] cw, input logic b, input logic d,
                      input logic a, input logic e, input logic [3:0] p);
    exp_t x;
    x.cw = cw; x.busy = b; x.done = d; x.abt = a; x.err = e; x.pc = p;
    sb.push_back(x);
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: got=no-expectation expected=queued-entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".ctrl_word"}, 32'(ctrl_word), 32'(e.cw));
      cmp({tag, ".busy"},      32'(busy),      32'(e.busy));
      cmp({tag, ".done"},      32'(done),      32'(e.done));
      cmp({tag, ".aborted"},   32'(aborted),   32'(e.abt));
      cmp({tag, ".cfg_err"},   32'(cfg_err),   32'(e.err));
      cmp({tag, ".pc"},        32'(pc),        32'(e.pc));
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [12:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic kick(input logic [4:0] len);
    prog_len = len; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Plain run of n words: words on cycles 1..n, done on n+1, then idle.
  task automatic push_prog(input int n, input bit zeros);
    for (int k = 0; k < n; k++)
      push(zeros ? 13'h0 : prog[k], 1'b1, 1'b0, 1'b0, 1'b0, 4'(k));
    push(13'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    push(13'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic run_plain(input string tag, input int n, input logic [4:0] len, input bit zeros);
    push_prog(n, zeros);
    kick(len);
    for (int k = 0; k <= n + 1; k++) begin
      if (k > 0) cyc();
      check(tag);
    end
  endtask

  initial begin
    prog[0] = 13'h000F; prog[1] = 13'h02BF; prog[2] = 13'h0408;
    prog[3] = 13'h1B5F; prog[4] = 13'h01E6;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    prog_len = '0; start = 1'b0; hold = 1'b0; abort = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    push(13'h0, 0, 0, 0, 0, 4'h0);
    check("reset");
    rst = 1'b0;
    cyc();

    for (int k = 0; k < 5; k++) wr(4'(k), prog[k]);

    // QFT-2 program, with a start request during the run that must be ignored
    push_prog(5, 1'b0);
    kick(5'd5);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) cyc();
      start = (k == 2);
      check("qft_run");
    end
    start = 1'b0;

    // One-cycle stall on the third run cycle
    push(prog[0], 1, 0, 0, 0, 4'd0);
    push(prog[1], 1, 0, 0, 0, 4'd1);
    push(13'h0400, 1, 0, 0, 0, 4'd2);
    push(prog[2], 1, 0, 0, 0, 4'd2);
    push(prog[3], 1, 0, 0, 0, 4'd3);
    push(prog[4], 1, 0, 0, 0, 4'd4);
    push(13'h0, 0, 1, 0, 0, 4'd0);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    kick(5'd5);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      hold = (k == 2);
      check("hold");
    end
    hold = 1'b0;

    // Zero-length program; start held through DONE, abort in IDLE
    push(13'h0, 0, 1, 0, 0, 4'd0);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    prog_len = 5'd0; start = 1'b1;
    cyc();
    check("len0_done");
    cyc();
    start = 1'b0; abort = 1'b1;
    check("len0_idle");
    cyc();
    abort = 1'b0;
    check("abort_idle");

    // Abort on run cycle 2, then a fresh replay from word 0
    push(prog[0], 1, 0, 0, 0, 4'd0);
    push(13'h0, 1, 0, 0, 0, 4'd1);
    push(13'h0, 0, 0, 1, 0, 4'd0);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    kick(5'd5);
    check("abort_c1");
    cyc();
    abort = 1'b1;
    check("abort_c2");
    cyc();
    abort = 1'b0;
    check("abort_c3");
    cyc();
    check("abort_c4");
    run_plain("replay", 5, 5'd5, 1'b0);

    // Config write during RUN is rejected
    push(prog[0], 1, 0, 0, 0, 4'd0);
    push(prog[1], 1, 0, 0, 0, 4'd1);
    push(prog[2], 1, 0, 0, 1, 4'd2);
    push(prog[3], 1, 0, 0, 0, 4'd3);
    push(prog[4], 1, 0, 0, 0, 4'd4);
    push(13'h0, 0, 1, 0, 0, 4'd0);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    kick(5'd5);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc();
      cfg_we = (k == 1); cfg_addr = 4'd2; cfg_data = 13'h1FFF;
      check("run_wr");
    end
    cfg_we = 1'b0;
    run_plain("rerun_kept", 5, 5'd5, 1'b0);

    // Same write in IDLE is accepted
    wr(4'd2, 13'h1FFF);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    check("idle_wr");
    prog[2] = 13'h1FFF;
    run_plain("rerun_new", 5, 5'd5, 1'b0);
    wr(4'd2, 13'h0408);
    prog[2] = 13'h0408;

    // Write and start in one cycle: run sees the new word
    push(13'h0ABC, 1, 0, 0, 0, 4'd0);
    push(13'h0, 0, 1, 0, 0, 4'd0);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 13'h0ABC;
    prog_len = 5'd1; start = 1'b1;
    cyc();
    cfg_we = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      check("wr_start");
    end
    wr(4'd0, 13'h000F);

    // Asynchronous reset on run cycle 3
    push(prog[0], 1, 0, 0, 0, 4'd0);
    push(prog[1], 1, 0, 0, 0, 4'd1);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    push(13'h0, 0, 0, 0, 0, 4'd0);
    kick(5'd5);
    check("rst_c1");
    cyc();
    check("rst_c2");
    cyc();
    #2;
    rst = 1'b1;
    check("rst_async");
    cyc();
    rst = 1'b0;
    check("rst_release");

    // Table cleared; oversized length saturates to 16 entries
    run_plain("cleared_sat", 16, 5'd20, 1'b1);
    run_plain("len1_after_rst", 1, 5'd1, 1'b1);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: got=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
